// File: rtl/cla_nibble_sequencer_pkg.sv
// Shared types and constants for the nibble-serial carry-lookahead add/subtract sequencer.
// Optional build macro CLA_SEQ_ACCUMULATE_EN is consumed by the top module, not here.
package cla_nibble_sequencer_pkg;

   localparam int unsigned NIBBLE = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Width of the nibble index; at least one bit even for the smallest legal WORDS.
   function automatic int unsigned idx_width(input int unsigned words);
      return (words > 32'd2) ? 32'($clog2(words)) : 32'd1;
   endfunction

endpackage

// File: rtl/cla_nibble_sequencer_cla4.sv
// Shared 4-bit carry-lookahead adder slice, purely combinational.
// Instantiated beside the sequencer by its parent and wired to the add_* ports.
module cla_nibble_sequencer_cla4
   import cla_nibble_sequencer_pkg::*;
(
   input  logic [NIBBLE-1:0] i_a,
   input  logic [NIBBLE-1:0] i_b,
   input  logic              i_cin,
   output logic [NIBBLE-1:0] o_s,
   output logic              o_cout
);

   logic [NIBBLE-1:0] w_g;
   logic [NIBBLE-1:0] w_p;
   logic [NIBBLE-1:0] w_c;

   assign w_g = i_a & i_b;
   assign w_p = i_a ^ i_b;

   // Flat lookahead equations: every carry derived directly from g/p and cin.
   assign w_c[0] = i_cin;
   assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
   assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
   assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                 | (w_p[2] & w_p[1] & w_p[0] & i_cin);
   assign o_cout = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                 | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                 | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_cin);

   assign o_s = w_p ^ w_c;

endmodule

// File: rtl/cla_nibble_sequencer.sv
// Multi-cycle WORDS*4-bit add/subtract driving an external 4-bit CLA slice, one nibble per clock.
// Build macro CLA_SEQ_ACCUMULATE_EN adds i_acc: operand A taken from the held result.
module cla_nibble_sequencer
   import cla_nibble_sequencer_pkg::*;
#(
   parameter int unsigned WORDS = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_start,
   input  logic                    i_sub,
`ifdef CLA_SEQ_ACCUMULATE_EN
   input  logic                    i_acc,
`endif
   input  logic [NIBBLE*WORDS-1:0] i_op_a,
   input  logic [NIBBLE*WORDS-1:0] i_op_b,
   output logic                    o_busy,
   output logic                    o_done,
   output logic [NIBBLE*WORDS-1:0] o_result,
   output logic                    o_carry_out,
   output logic                    o_overflow,
   output logic [NIBBLE-1:0]       o_add_a,
   output logic [NIBBLE-1:0]       o_add_b,
   output logic                    o_add_cin,
   input  logic [NIBBLE-1:0]       i_add_s,
   input  logic                    i_add_cout
);

   localparam int unsigned IW = idx_width(WORDS);

   state_e                         r_state;
   state_e                         w_next;
   logic [WORDS-1:0][NIBBLE-1:0]   r_a;
   logic [WORDS-1:0][NIBBLE-1:0]   r_b;
   logic [WORDS-1:0][NIBBLE-1:0]   r_result;
   logic                           r_carry;
   logic [IW-1:0]                  r_idx;
   logic                           r_busy;
   logic                           r_done;
   logic                           r_carry_out;
   logic                           r_overflow;
   logic                           w_last;
   logic                           w_ovf;

   // Next state plus the combinational nibble mux toward the adder slice.
   always_comb begin
      w_next    = r_state;
      o_add_a   = '0;
      o_add_b   = '0;
      o_add_cin = 1'b0;
      w_last    = (r_idx == IW'(WORDS - 1));
      w_ovf     = (r_a[WORDS-1][NIBBLE-1] == r_b[WORDS-1][NIBBLE-1])
               && (i_add_s[NIBBLE-1] != r_a[WORDS-1][NIBBLE-1]);
      case (r_state)
         IDLE: begin
            if (i_start) begin
               w_next = RUN;
            end
         end
         RUN: begin
            o_add_a   = r_a[r_idx];
            o_add_b   = r_b[r_idx];
            o_add_cin = r_carry;
            if (w_last) begin
               w_next = DONE;
            end
         end
         DONE: begin
            w_next = IDLE;
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_a         <= '0;
         r_b         <= '0;
         r_result    <= '0;
         r_carry     <= 1'b0;
         r_idx       <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_carry_out <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_busy  <= (w_next != IDLE);
         r_done  <= (w_next == DONE);
         case (r_state)
            IDLE: begin
               if (i_start) begin
`ifdef CLA_SEQ_ACCUMULATE_EN
                  // Running mode reuses the held result; nibbles are overwritten as they finish.
                  r_a <= i_acc ? r_result : i_op_a;
`else
                  r_a      <= i_op_a;
                  r_result <= '0;
`endif
                  r_b         <= i_sub ? ~i_op_b : i_op_b;
                  r_carry     <= i_sub;
                  r_idx       <= '0;
                  r_carry_out <= 1'b0;
                  r_overflow  <= 1'b0;
               end
            end
            RUN: begin
               r_result[r_idx] <= i_add_s;
               r_carry         <= i_add_cout;
               if (w_last) begin
                  r_carry_out <= i_add_cout;
                  r_overflow  <= w_ovf;
               end else begin
                  r_idx <= r_idx + IW'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign o_busy      = r_busy;
   assign o_done      = r_done;
   assign o_result    = r_result;
   assign o_carry_out = r_carry_out;
   assign o_overflow  = r_overflow;

endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// Self-checking bench: sequencer plus CLA slice, directed and random ops vs an arithmetic model.
// Accumulate checks run only when CLA_SEQ_ACCUMULATE_EN is defined.
module tb_cla_nibble_sequencer;

   localparam int unsigned WORDS = 4;
   localparam int unsigned W     = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_start;
   logic          i_sub;
`ifdef CLA_SEQ_ACCUMULATE_EN
   logic          i_acc;
`endif
   logic [W-1:0]  i_op_a;
   logic [W-1:0]  i_op_b;
   logic          o_busy;
   logic          o_done;
   logic [W-1:0]  o_result;
   logic          o_carry_out;
   logic          o_overflow;
   logic [3:0]    w_add_a;
   logic [3:0]    w_add_b;
   logic          w_add_cin;
   logic [3:0]    w_add_s;
   logic          w_add_cout;

   int            n_pass = 0;
   int            n_checks = 0;
   int            done_pulses = 0;
   logic [W-1:0]  prev_result = '0;
   logic [3:0]    last_cins;

   always #5 clk = ~clk;

   cla_nibble_sequencer #(.WORDS(WORDS)) dut (
      .clk         (clk),
      .rst         (rst),
      .i_start     (i_start),
      .i_sub       (i_sub),
`ifdef CLA_SEQ_ACCUMULATE_EN
      .i_acc       (i_acc),
`endif
      .i_op_a      (i_op_a),
      .i_op_b      (i_op_b),
      .o_busy      (o_busy),
      .o_done      (o_done),
      .o_result    (o_result),
      .o_carry_out (o_carry_out),
      .o_overflow  (o_overflow),
      .o_add_a     (w_add_a),
      .o_add_b     (w_add_b),
      .o_add_cin   (w_add_cin),
      .i_add_s     (w_add_s),
      .i_add_cout  (w_add_cout)
   );

   cla_nibble_sequencer_cla4 u_slice (
      .i_a    (w_add_a),
      .i_b    (w_add_b),
      .i_cin  (w_add_cin),
      .o_s    (w_add_s),
      .o_cout (w_add_cout)
   );

   always @(posedge clk) begin
      if (o_done === 1'b1) done_pulses <= done_pulses + 1;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Reference: plain integer arithmetic on W-bit unsigned and signed views.
   function automatic void ref_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                  output logic [W-1:0] r, output logic co, output logic ov);
      int ua, ub, sa, sb, sr;
      ua = int'(a);
      ub = int'(b);
      sa = (ua > 32767) ? ua - 65536 : ua;
      sb = (ub > 32767) ? ub - 65536 : ub;
      if (s) begin
         r  = 16'(ua - ub);
         co = (ua >= ub);
         sr = sa - sb;
      end else begin
         r  = 16'(ua + ub);
         co = ((ua + ub) > 65535);
         sr = sa + sb;
      end
      ov = (sr > 32767) || (sr < -32768);
   endfunction

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input logic acc, input logic poke,
                         output int done_k, output int busy_n, output logic [3:0] cins);
      @(negedge clk);
      i_start = 1'b1; i_op_a = a; i_op_b = b; i_sub = s;
`ifdef CLA_SEQ_ACCUMULATE_EN
      i_acc = acc;
`else
      if (acc) $display("note: accumulate requested without the feature");
`endif
      @(negedge clk);
      i_start = 1'b0;
      i_op_a = W'($urandom); i_op_b = W'($urandom); i_sub = 1'($urandom);
      done_k = -1; busy_n = 0; cins = '0;
      for (int k = 0; k < 20; k++) begin
         if (o_busy) busy_n++;
         if (o_done) begin
            done_k = k;
            break;
         end
         if (k < 4) cins[k] = w_add_cin;
         if (poke && k == 1) begin
            i_start = 1'b1; i_op_a = 16'hAAAA;
         end else begin
            i_start = 1'b0;
         end
         @(negedge clk);
      end
      i_start = 1'b0;
      @(negedge clk);
   endtask

   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input logic acc, input logic poke);
      logic [W-1:0] er, aeff;
      logic         eco, eov;
      int           dk, bn, dp0;
      logic [3:0]   cins;
      aeff = acc ? prev_result : a;
      ref_op(aeff, b, s, er, eco, eov);
      dp0 = done_pulses;
      run_op(a, b, s, acc, poke, dk, bn, cins);
      check("result", 32'(o_result), 32'(er));
      check("carry_out", 32'(o_carry_out), 32'(eco));
      check("overflow", 32'(o_overflow), 32'(eov));
      check("done_latency", 32'(dk), 32'(WORDS));
      check("busy_cycles", 32'(bn), 32'(WORDS + 1));
      check("done_pulses", 32'(done_pulses - dp0), 32'd1);
      check("idle_after_done", {30'd0, o_busy, o_done}, 32'd0);
      prev_result = er;
      last_cins = cins;
   endtask

   initial begin
      int dp0;
      rst = 1'b1; i_start = 1'b0; i_sub = 1'b0; i_op_a = '0; i_op_b = '0;
`ifdef CLA_SEQ_ACCUMULATE_EN
      i_acc = 1'b0;
`endif
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(o_busy), 32'd0);
      check("rst_done", 32'(o_done), 32'd0);
      check("rst_result", 32'(o_result), 32'd0);
      check("rst_flags", {30'd0, o_carry_out, o_overflow}, 32'd0);
      check("rst_add", {23'd0, w_add_a, w_add_b, w_add_cin}, 32'd0);
      rst = 1'b0;

      do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0);
      check("t1_result_const", 32'(o_result), 32'h5555);
      do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
      check("t2_cin_seq", 32'(last_cins), 32'hE);
      check("t2_result_const", {15'd0, o_carry_out, o_result}, 32'h1_0000);
      do_op(16'h0005, 16'h0007, 1'b1, 1'b0, 1'b0);
      check("t3_result_const", {15'd0, o_carry_out, o_result}, 32'h0_FFFE);
      do_op(16'h8000, 16'h0001, 1'b1, 1'b0, 1'b0);
      check("t3b_const", {14'd0, o_overflow, o_carry_out, o_result}, 32'h3_7FFF);
      do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1);
      check("t4_ignored_start", {15'd0, o_overflow, o_result}, 32'h1_8000);

      // Async reset during the second RUN cycle.
      @(negedge clk);
      i_start = 1'b1; i_op_a = 16'h1111; i_op_b = 16'h2222; i_sub = 1'b0;
      @(negedge clk);
      i_start = 1'b0;
      @(negedge clk);
      check("t5_running", 32'(o_busy), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("t5_rst_busy", {30'd0, o_busy, o_done}, 32'd0);
      check("t5_rst_result", 32'(o_result), 32'd0);
      check("t5_rst_add", {23'd0, w_add_a, w_add_b, w_add_cin}, 32'd0);
      dp0 = done_pulses;
      @(negedge clk);
      rst = 1'b0;
      repeat (8) @(negedge clk);
      check("t5_no_done", 32'(done_pulses - dp0), 32'd0);
      check("t5_idle", 32'(o_busy), 32'd0);
      prev_result = '0;
      do_op(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0);
      check("t5_after_const", 32'(o_result), 32'h0002);

`ifdef CLA_SEQ_ACCUMULATE_EN
      do_op(16'h0010, 16'h0005, 1'b0, 1'b0, 1'b0);
      check("t6_first", 32'(o_result), 32'h0015);
      do_op(16'hBEEF, 16'h0003, 1'b0, 1'b1, 1'b0);
      check("t6_acc_add", 32'(o_result), 32'h0018);
      do_op(16'h1234, 16'h0018, 1'b1, 1'b1, 1'b0);
      check("t6_acc_sub", {15'd0, o_carry_out, o_result}, 32'h1_0000);
`endif

      for (int i = 0; i < 24; i++) begin
         logic acc_r;
`ifdef CLA_SEQ_ACCUMULATE_EN
         acc_r = 1'($urandom);
`else
         acc_r = 1'b0;
`endif
         do_op(W'($urandom), W'($urandom), 1'($urandom), acc_r, 1'($urandom));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
